// File: rtl/data_gen.sv
// rtl/data_gen.sv - incrementing-word test-pattern source for the TX FIFO write port
// Optional: DATA_GEN_ERR_INJECT_EN flips bit 0 of word ERR_INDEX.
module data_gen #(
    parameter int unsigned WORDS      = 1024,
    parameter int unsigned BURST_LEN  = 256,
    parameter int unsigned GAP_CYCLES = 4,
    parameter int unsigned ERR_INDEX  = 5
) (
    input  logic        clk_in,
    input  logic        rst,
    input  logic        start,
    input  logic        tx_full,
    output logic        tx_write,
    output logic [31:0] tx_data,
    output logic        busy,
    output logic        done
);

    localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [31:0]   LAST_WORD  = 32'(WORDS - 1);
    localparam logic [31:0]   ERR_WORD   = 32'(ERR_INDEX);
    localparam logic [BW-1:0] BURST_LAST = BW'(BURST_LEN - 1);
    localparam logic [GW-1:0] GAP_LAST   = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam bit            HAS_GAP    = (GAP_CYCLES > 0);

`ifdef DATA_GEN_ERR_INJECT_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SEND = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [31:0]   word_q, word_d;
    logic [BW-1:0] burst_q, burst_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          err_hit;

    // The word counter stops on the last word so DONE presents WORDS-1 without a separate hold register.
    always_comb begin
        state_d  = state_q;
        word_d   = word_q;
        burst_d  = burst_q;
        gap_d    = gap_q;
        tx_write = (state_q == SEND) && !tx_full;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = SEND;
                    word_d  = '0;
                    burst_d = '0;
                    gap_d   = '0;
                end
            end
            SEND: begin
                if (tx_write) begin
                    if (word_q == LAST_WORD) begin
                        state_d = DONE;
                    end else begin
                        word_d = word_q + 32'd1;
                        if (burst_q == BURST_LAST) begin
                            burst_d = '0;
                            gap_d   = '0;
                            if (HAS_GAP) begin
                                state_d = GAP;
                            end
                        end else begin
                            burst_d = burst_q + 1'b1;
                        end
                    end
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    gap_d   = '0;
                    state_d = SEND;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q <= IDLE;
            word_q  <= '0;
            burst_q <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            burst_q <= burst_d;
            gap_q   <= gap_d;
        end
    end

    assign err_hit = ERR_EN && (state_q == SEND) && (word_q == ERR_WORD);
    assign tx_data = word_q ^ {31'b0, err_hit};
    assign busy    = (state_q == SEND) || (state_q == GAP);
    assign done    = (state_q == DONE);

endmodule

// File: doc/data_gen.md
# data_gen

Test-pattern source for the master FIFO link. On a start pulse it writes an incrementing 32-bit word sequence (0, 1, 2, …) into the TX FIFO write port. Words go out in bursts separated by programmable idle gaps. The downstream FIFO carries the words to the receive-side checker, which expects exactly this sequence starting at 0.

## Interface
Parameters:
- WORDS, 1024: total words per run (≥1, ≤2^32−1).
- BURST_LEN, 256: words per burst before a gap (≥1).
- GAP_CYCLES, 4: idle cycles between bursts; 0 = no gaps.
- ERR_INDEX, 5: word index corrupted when error injection is compiled in.

Ports:
- clk_in  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle run request.
- tx_full  input  1  FIFO full flag; no write may occur while high.
- tx_write  output  1  FIFO write strobe; word accepted on every clk_in edge where high.
- tx_data  output  32  word presented with tx_write.
- busy  output  1  high in SEND or GAP.
- done  output  1  high in DONE.

## Operation
- FSM states: IDLE, SEND, GAP, DONE. Reset forces IDLE.
- **IDLE:** start=1 → SEND. Word counter, burst counter and gap counter all clear to 0.
- **SEND:** tx_write = !tx_full (combinational from registered state and tx_full). tx_data = word counter.
- **Accepted write** (tx_write=1 at an edge): word counter +1 and burst counter +1.
  - Last word (counter = WORDS−1) → DONE. No gap follows the final burst.
  - Otherwise, burst counter = BURST_LEN−1 → GAP if GAP_CYCLES>0, else stay in SEND. Either way the burst counter clears.
- **GAP:** tx_write=0. The gap counter runs 0..GAP_CYCLES−1, then returns to SEND. tx_full is ignored.
- **DONE:** tx_write=0; tx_data holds WORDS−1. start=1 → SEND with all counters cleared (new run from 0).
- start is ignored in SEND and GAP.
- Width rules:
  - Counters are 32 bits; tx_data is the word counter value, unsigned, with no wrap within a run.
  - The burst and gap counters are sized by $clog2 of their parameter, minimum 1 bit.
- Reset values: tx_write=0, tx_data=0, busy=0, done=0, state=IDLE.

## Timing
- Latency: start sampled at edge E → tx_write may assert in the cycle after E. Word 0 is written at edge E+1 if tx_full=0.
- Full throughput with tx_full=0: one word per cycle within a burst.
- Run length with tx_full=0: WORDS + GAP_CYCLES·(ceil(WORDS/BURST_LEN)−1) cycles from E to DONE entry.
- Backpressure:
  - tx_full rising mid-burst deasserts tx_write in the same cycle. tx_data holds and no word is skipped or duplicated.
  - tx_full=1 exactly on the last word of a burst delays the GAP entry until that word is accepted.
- rst mid-run: returns to IDLE at the next edge and abandons the partial run. The next start begins again at 0.
- start and rst in the same cycle: rst wins.

## Configuration
- Macro: DATA_GEN_ERR_INJECT_EN.
- Defined: the word with index ERR_INDEX is sent with bit 0 inverted. All other words are unchanged and the counter sequence is unaffected. This exercises the checker's failure path.
- Undefined: the pattern is pure; ERR_INDEX is unused.

## Test plan
- Default params, tx_full=0, start pulse → 1024 writes with data 0..1023. 4-cycle gaps follow words 255, 511 and 767. done rises 1036 cycles after the start edge, and busy falls at the same edge.
- tx_full held high for 10 cycles starting at word 100 → tx_write low for those 10 cycles, tx_data stays 100, word 100 is written exactly once, and the sequence is contiguous.
- rst asserted at word 300 → next cycle all outputs at reset values. A new start yields word 0 first.
- start re-pulsed during SEND at word 50 → ignored, sequence continues at 51. start pulsed in DONE → fresh run from 0.
- GAP_CYCLES=0, BURST_LEN=1, WORDS=3 → writes 0,1,2 on three consecutive cycles, then done=1.
- DATA_GEN_ERR_INJECT_EN defined → word 5 carries 0x00000004 and all other words equal their index. The downstream checker leaves its pass LED low.
